// File: rtl/instruction_fetch.sv
// Instruction fetch stage: word-addressed instruction memory, program counter
// and a single registered output stage with a valid/ready handshake and RV32
// field decode. Sequential advance, stall, redirect/flush, program loading and
// a sticky out-of-range fault.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (fault on misaligned redirect).
module instruction_fetch #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              instr,
  output logic [31:0]              pc_out,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [2:0]               funct3,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [6:0]               funct7,
  output logic                     fault
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] PC_LIMIT = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        in_range;
  logic        advance;
  logic [31:0] redir_target;
  logic        redir_fault;

  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_out_d;
  logic        fault_d;

  // Program load port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Combinational read; a same-cycle load is seen only from the next edge.
  assign rdata    = mem[pc[AW+1:2]];
  assign in_range = {1'b0, pc} < PC_LIMIT;
  assign advance  = !out_valid || out_ready;

`ifdef IFETCH_MISALIGN_CHECK_EN
  // Misaligned target loads as-is and parks the stage in fault.
  assign redir_target = redirect_pc;
  assign redir_fault  = |redirect_pc[1:0];
`else
  // Low address bits are dropped; a redirect always clears the fault.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = |redirect_pc[1:0];
  assign redir_target = {redirect_pc[31:2], 2'b00};
  assign redir_fault  = 1'b0;
`endif

  // Next-state: redirect > fault hold > advance > hold.
  always_comb begin
    pc_d     = pc;
    valid_d  = out_valid;
    instr_d  = instr;
    pc_out_d = pc_out;
    fault_d  = fault;
    if (redirect) begin
      pc_d    = redir_target;
      valid_d = 1'b0;
      fault_d = redir_fault;
    end else if (fault) begin
      valid_d = 1'b0;
    end else if (advance) begin
      if (in_range) begin
        instr_d  = rdata;
        pc_out_d = pc;
        valid_d  = 1'b1;
        pc_d     = pc + 32'd4;
      end else begin
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      instr     <= 32'h0;
      pc_out    <= 32'h0;
      fault     <= 1'b0;
    end else begin
      pc        <= pc_d;
      out_valid <= valid_d;
      instr     <= instr_d;
      pc_out    <= pc_out_d;
      fault     <= fault_d;
    end
  end

  // Decoded fields are fixed slices of the registered instruction word.
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a DEPTH=16 instance for the main flow
// and a DEPTH=4 instance sharing the stimulus for range-fault behaviour.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        out_valid, fault;
  logic [31:0] instr, pc_out;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  logic        out_valid4, fault4;
  logic [31:0] instr4, pc_out4;
  logic [6:0]  opcode4, funct74;
  logic [4:0]  rd4, rs14, rs24;
  logic [2:0]  funct34;

  logic [31:0] w [8];
  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .instr(instr), .pc_out(pc_out),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .fault(fault)
  );

  instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .reset(reset), .load_en(load_en && (load_addr < 4'd4)),
    .load_addr(load_addr[1:0]), .load_data(load_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_ready(out_ready), .out_valid(out_valid4),
    .instr(instr4), .pc_out(pc_out4), .opcode(opcode4), .rd(rd4),
    .funct3(funct34), .rs1(rs14), .rs2(rs24), .funct7(funct74), .fault(fault4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    w[0] = 32'h00500093; w[1] = 32'h00A00113; w[2] = 32'h002081B3; w[3] = 32'h40110233;
    w[4] = 32'h00000013; w[5] = 32'h12345678; w[6] = 32'hCAFEF00D; w[7] = 32'h0BADC0DE;
    reset = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    load_en = 1'b0; load_addr = 4'h0; load_data = 32'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = w[i];
      step();
    end
    load_en = 1'b0;
    n_cmp++;
    if ({out_valid, fault, pc_out, instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got v=%0b f=%0b pc=%h instr=%h, want 0/0/0/0", out_valid, fault, pc_out, instr);
    end
    n_cmp++;
    if ({opcode, rd, funct3, rs1, rs2, funct7} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_fields: got nonzero fields op=%h rd=%0d", opcode, rd);
    end
    n_cmp++;
    if ({out_valid4, fault4} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state4: got v=%0b f=%0b, want 0/0", out_valid4, fault4);
    end
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({out_valid, pc_out, instr} !== {1'b1, 32'(4 * k), w[k]}) begin
        n_err++;
        $display("FAIL seq_beat%0d: got v=%0b pc=%h instr=%h, want 1/%h/%h", k, out_valid, pc_out, instr, 32'(4 * k), w[k]);
      end
      if (k == 2) begin
        n_cmp++;
        if ({opcode, rd, rs1, rs2, funct3, funct7} !== {7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00}) begin
          n_err++;
          $display("FAIL seq_decode2: got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h", opcode, rd, rs1, rs2, funct3, funct7);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (funct7 !== 7'h20) begin
          n_err++;
          $display("FAIL seq_funct7_3: got %h, want 20", funct7);
        end
      end
    end
  endtask

  task automatic test_range_fault();
    step();
    n_cmp++;
    if ({fault4, out_valid4} !== 2'b10) begin
      n_err++;
      $display("FAIL range_fault_rise: got f=%0b v=%0b, want 1/0", fault4, out_valid4);
    end
    n_cmp++;
    if ({out_valid, fault, pc_out, instr} !== {1'b1, 1'b0, 32'h10, w[4]}) begin
      n_err++;
      $display("FAIL range_big_inrange: got v=%0b f=%0b pc=%h instr=%h, want 1/0/10/%h", out_valid, fault, pc_out, instr, w[4]);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({fault4, out_valid4, pc_out4} !== {1'b1, 1'b0, 32'hC}) begin
        n_err++;
        $display("FAIL range_fault_hold%0d: got f=%0b v=%0b pc=%h, want 1/0/c", i, fault4, out_valid4, pc_out4);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    n_cmp++;
    if ({fault4, out_valid4, out_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL range_redirect_clear: got f4=%0b v4=%0b v=%0b, want 0/0/0", fault4, out_valid4, out_valid);
    end
    step();
    n_cmp++;
    if ({out_valid4, pc_out4, instr4} !== {1'b1, 32'h0, w[0]}) begin
      n_err++;
      $display("FAIL range_resume: got v=%0b pc=%h instr=%h, want 1/0/%h", out_valid4, pc_out4, instr4, w[0]);
    end
  endtask

  task automatic test_stall();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({out_valid, pc_out, instr} !== {1'b1, 32'h4, w[1]}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%0b pc=%h instr=%h, want 1/4/%h", i, out_valid, pc_out, instr, w[1]);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h8, w[2]}) begin
      n_err++;
      $display("FAIL stall_release: got v=%0b pc=%h instr=%h, want 1/8/%h", out_valid, pc_out, instr, w[2]);
    end
    step();
    n_cmp++;
    if (pc_out !== 32'hC) begin
      n_err++;
      $display("FAIL stall_next: got pc=%h, want c", pc_out);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    n_cmp++;
    if ({out_valid, pc_out} !== {1'b0, 32'hC}) begin
      n_err++;
      $display("FAIL redirect_bubble: got v=%0b pc=%h, want 0/c", out_valid, pc_out);
    end
    step();
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h10, w[4]}) begin
      n_err++;
      $display("FAIL redirect_target: got v=%0b pc=%h instr=%h, want 1/10/%h", out_valid, pc_out, instr, w[4]);
    end
    step();
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h14, w[5]}) begin
      n_err++;
      $display("FAIL redirect_follow: got v=%0b pc=%h instr=%h, want 1/14/%h", out_valid, pc_out, instr, w[5]);
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_bubble: got v=%0b, want 0", out_valid);
    end
    step();
`ifdef IFETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({fault, out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL misalign_fault%0d: got f=%0b v=%0b, want 1/0", i, fault, out_valid);
      end
      step();
    end
`else
    n_cmp++;
    if ({out_valid, fault, pc_out, instr} !== {1'b1, 1'b0, 32'h4, w[1]}) begin
      n_err++;
      $display("FAIL misalign_align: got v=%0b f=%0b pc=%h instr=%h, want 1/0/4/%h", out_valid, fault, pc_out, instr, w[1]);
    end
`endif
  endtask

  task automatic test_async_reset();
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    step();
    n_cmp++;
    if ({fault4, out_valid, pc_out, fault} !== {1'b1, 1'b1, 32'h10, 1'b0}) begin
      n_err++;
      $display("FAIL areset_setup: got f4=%0b v=%0b pc=%h f=%0b, want 1/1/10/0", fault4, out_valid, pc_out, fault);
    end
    out_ready = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, fault, pc_out, instr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL areset_immediate: got v=%0b f=%0b pc=%h instr=%h, want 0/0/0/0", out_valid, fault, pc_out, instr);
    end
    n_cmp++;
    if ({fault4, out_valid4} !== 2'b00) begin
      n_err++;
      $display("FAIL areset_fault4: got f=%0b v=%0b, want 0/0", fault4, out_valid4);
    end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h0, w[0]}) begin
      n_err++;
      $display("FAIL areset_first_beat: got v=%0b pc=%h instr=%h, want 1/0/%h", out_valid, pc_out, instr, w[0]);
    end
    step();
    n_cmp++;
    if (pc_out !== 32'h4) begin
      n_err++;
      $display("FAIL areset_second_beat: got pc=%h, want 4", pc_out);
    end
  endtask

  task automatic test_load_collision();
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_en = 1'b1; load_addr = 4'h0; load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h0, w[0]}) begin
      n_err++;
      $display("FAIL collision_old: got v=%0b pc=%h instr=%h, want 1/0/%h", out_valid, pc_out, instr, w[0]);
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    n_cmp++;
    if ({out_valid, pc_out, instr} !== {1'b1, 32'h0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL collision_new: got v=%0b pc=%h instr=%h, want 1/0/deadbeef", out_valid, pc_out, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_range_fault();
    test_stall();
    test_redirect();
    test_misalign();
    test_async_reset();
    test_load_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
